// File: rtl/uart_tx_fsm.sv
// UART transmit frame sequencer: gates the load strobe and steps start, data,
// optional parity and stop bits, one bit per CLK.
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    output logic       dv_gate,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       busy
);

    localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_bit_cnt;
    logic [CntW-1:0]   w_bit_cnt_next;
    logic              r_par_en;
    logic              w_par_en_next;
    logic              w_accept;

    assign w_accept = (r_state == StIdle) || (r_state == StStop);
    // RST term keeps the strobe masked while reset holds the FSM in idle.
    assign dv_gate  = Data_Valid & w_accept & RST;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= StIdle;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_par_en  <= w_par_en_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_cnt_next = r_bit_cnt;
        w_par_en_next  = r_par_en;
        case (r_state)
            StIdle: begin
                if (dv_gate) begin
                    w_state_next  = StStart;
                    w_par_en_next = PAR_EN;
                end
            end
            StStart: begin
                w_state_next   = StData;
                w_bit_cnt_next = '0;
            end
            StData: begin
                if (r_bit_cnt == CntMax) begin
                    w_state_next   = r_par_en ? StParity : StStop;
                    w_bit_cnt_next = '0;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + CntW'(1);
                end
            end
            StParity: begin
                w_state_next = StStop;
            end
            StStop: begin
                if (dv_gate) begin
                    w_state_next  = StStart;
                    w_par_en_next = PAR_EN;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_comb begin
        ser_en  = 1'b0;
        mux_sel = 2'b01;
        busy    = 1'b0;
        case (r_state)
            StStart: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            StData: begin
                mux_sel = 2'b10;
                ser_en  = 1'b1;
                busy    = 1'b1;
            end
            StParity: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
            StStop: begin
                busy = 1'b1;
            end
            default: begin
                ser_en  = 1'b0;
                mux_sel = 2'b01;
                busy    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed self-checking bench for uart_tx_fsm at the default 8-bit width.
module tb_uart_tx_fsm;

    logic       CLK;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       dv_gate;
    logic       ser_en;
    logic [1:0] mux_sel;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;

    uart_tx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .dv_gate    (dv_gate),
        .ser_en     (ser_en),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        RST        = 1'b0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            Data_Valid = i[0];
            #1;
            n_total++;
            if (dv_gate !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_dv_gate: got %b want 0", dv_gate);
            end
            n_total++;
            if ({mux_sel, busy, ser_en} !== 4'b0100) begin
                n_bad++;
                $display("FAIL reset_outputs: mux/busy/ser got %b want 0100",
                         {mux_sel, busy, ser_en});
            end
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        RST        = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_total++;
            if ({mux_sel, busy, ser_en} !== 4'b0100) begin
                n_bad++;
                $display("FAIL idle_outputs: cycle %0d got %b want 0100", i,
                         {mux_sel, busy, ser_en});
            end
        end
    endtask

    // One frame; optionally poke Data_Valid every non-STOP cycle and drop PAR_EN mid-DATA.
    task automatic test_frame(input bit par, input bit disturb, input bit drop_par);
        int len;
        int busy_cnt;
        logic [1:0] exp_mux;
        logic       exp_ser;
        len      = 10 + int'(par);
        busy_cnt = 0;
        @(negedge CLK);
        Data_Valid = 1'b1;
        PAR_EN     = par;
        #1;
        n_total++;
        if (dv_gate !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_dv_gate: got %b want 1", dv_gate);
        end
        @(negedge CLK);
        for (int k = 0; k < len; k++) begin
            Data_Valid = 1'b0;
            if (k == 0) begin
                exp_mux = 2'b00; exp_ser = 1'b0;
            end else if (k <= 8) begin
                exp_mux = 2'b10; exp_ser = 1'b1;
            end else if (par && k == 9) begin
                exp_mux = 2'b11; exp_ser = 1'b0;
            end else begin
                exp_mux = 2'b01; exp_ser = 1'b0;
            end
            if (busy === 1'b1) busy_cnt++;
            n_total++;
            if ({mux_sel, ser_en, busy} !== {exp_mux, exp_ser, 1'b1}) begin
                n_bad++;
                $display("FAIL frame_step: par=%0b k=%0d mux/ser/busy got %b want %b",
                         par, k, {mux_sel, ser_en, busy}, {exp_mux, exp_ser, 1'b1});
            end
            if (drop_par && k == 3) PAR_EN = 1'b0;
            if (disturb && k < len - 1) begin
                Data_Valid = 1'b1;
                #1;
                n_total++;
                if (dv_gate !== 1'b0) begin
                    n_bad++;
                    $display("FAIL busy_dv_gate: k=%0d got %b want 0", k, dv_gate);
                end
            end
            @(negedge CLK);
        end
        Data_Valid = 1'b0;
        n_total++;
        if ({mux_sel, busy, ser_en} !== 4'b0100) begin
            n_bad++;
            $display("FAIL frame_end_idle: got %b want 0100", {mux_sel, busy, ser_en});
        end
        n_total++;
        if (busy_cnt !== len) begin
            n_bad++;
            $display("FAIL busy_length: got %0d want %0d", busy_cnt, len);
        end
        PAR_EN = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_mux;
        @(negedge CLK);
        Data_Valid = 1'b1;
        PAR_EN     = 1'b0;
        @(negedge CLK);
        for (int k = 0; k < 20; k++) begin
            case (k % 10)
                0:       exp_mux = 2'b00;
                9:       exp_mux = 2'b01;
                default: exp_mux = 2'b10;
            endcase
            n_total++;
            if ({mux_sel, busy} !== {exp_mux, 1'b1}) begin
                n_bad++;
                $display("FAIL b2b_step: k=%0d mux/busy got %b want %b", k,
                         {mux_sel, busy}, {exp_mux, 1'b1});
            end
            n_total++;
            if (dv_gate !== ((k % 10) == 9)) begin
                n_bad++;
                $display("FAIL b2b_dv_gate: k=%0d got %b want %b", k, dv_gate,
                         ((k % 10) == 9));
            end
            if (k == 19) Data_Valid = 1'b0;
            @(negedge CLK);
        end
        n_total++;
        if ({mux_sel, busy} !== 3'b010) begin
            n_bad++;
            $display("FAIL b2b_end_idle: got %b want 010", {mux_sel, busy});
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CLK);
        Data_Valid = 1'b1;
        PAR_EN     = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        // negedges 1..4 are DATA cycles; stop on the 4th
        for (int k = 0; k < 4; k++) @(negedge CLK);
        n_total++;
        if ({mux_sel, ser_en} !== 3'b101) begin
            n_bad++;
            $display("FAIL pre_reset_data: got %b want 101", {mux_sel, ser_en});
        end
        #1;
        RST        = 1'b0;
        Data_Valid = 1'b1;
        #1;
        n_total++;
        if ({mux_sel, busy, ser_en, dv_gate} !== 5'b01000) begin
            n_bad++;
            $display("FAIL async_reset: mux/busy/ser/dv got %b want 01000",
                     {mux_sel, busy, ser_en, dv_gate});
        end
        @(negedge CLK);
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        RST        = 1'b1;
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, 1'b0, 1'b0);
        test_frame(1'b1, 1'b0, 1'b1);
        test_back_to_back();
        test_frame(1'b0, 1'b1, 1'b0);
        test_frame(1'b1, 1'b1, 1'b0);
        test_reset_mid_frame();
        test_frame(1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
